// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multicycle MIPS core: owns PC/EPC, runs the
// instruction-fetch handshake with a wait timeout, and applies prioritized redirects.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
   parameter int          MAX_WAIT   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        busy,
   input  logic        br_take,
   input  logic [15:0] br_offset,
   input  logic        jmp,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   input  logic        exc,
   output logic [31:0] pc,
   output logic [31:0] epc,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

   localparam logic [7:0] MAX_W = MAX_WAIT[7:0];

   state_t      state;
   logic [7:0]  wait_cnt;
   logic [31:0] br_target;
   logic [31:0] jmp_target;

   assign br_target  = pc + {{14{br_offset[15]}}, br_offset, 2'b00};
   assign jmp_target = {pc[31:28], instr[25:0], 2'b00};

   // Memory-side outputs depend on registered state only.
   assign busy      = (state == FETCH);
   assign imem_req  = busy;
   assign imem_addr = busy ? pc : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         pc          <= RESET_PC;
         epc         <= 32'h0;
         instr       <= 32'h0;
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         fetch_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (exc) begin
                  epc <= pc - 32'd4;
                  pc  <= EXC_VECTOR;
               end else if (start) begin
                  state    <= FETCH;
                  wait_cnt <= 8'd0;
               end
            end
            FETCH: begin
               // An exception aborts the fetch even if data arrives this cycle.
               if (exc) begin
                  epc   <= pc - 32'd4;
                  pc    <= EXC_VECTOR;
                  state <= IDLE;
               end else if (imem_ready) begin
                  instr       <= imem_data;
                  pc          <= pc + 32'd4;
                  instr_valid <= 1'b1;
                  state       <= EXEC;
               end else if (wait_cnt == MAX_W) begin
                  fetch_err <= 1'b1;
                  epc       <= pc;
                  pc        <= EXC_VECTOR;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            EXEC: begin
               if (exc) begin
                  epc <= pc - 32'd4;
                  pc  <= EXC_VECTOR;
               end else if (jr) begin
                  pc <= jr_addr;
               end else if (jmp) begin
                  pc <= jmp_target;
               end else if (br_take) begin
                  pc <= br_target;
               end
               if (start) begin
                  state    <= FETCH;
                  wait_cnt <= 8'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then randomized cycles, every cycle
// checked against a behavioural model of the fetch/redirect rules.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_0080;
   localparam int          MAX_WAIT   = 3;

   logic        clk = 1'b0;
   logic        reset, start, imem_ready, br_take, jmp, jr, exc;
   logic [31:0] imem_data, jr_addr;
   logic [15:0] br_offset;
   logic        imem_req, instr_valid, busy, fetch_err;
   logic [31:0] imem_addr, instr, pc, epc;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase of the sequencer plus the architectural registers.
   localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2;
   int          m_phase;
   int          m_lows;
   logic [31:0] m_pc, m_epc, m_instr;
   logic        m_iv, m_fe;

   pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
      .instr(instr), .instr_valid(instr_valid), .busy(busy),
      .br_take(br_take), .br_offset(br_offset), .jmp(jmp), .jr(jr), .jr_addr(jr_addr),
      .exc(exc), .pc(pc), .epc(epc), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic take_exc();
      m_epc = m_pc - 32'd4;
      m_pc  = EXC_VECTOR;
   endtask

   task automatic model_step();
      m_iv = 1'b0;
      m_fe = 1'b0;
      if (reset) begin
         m_pc = RESET_PC; m_epc = 0; m_instr = 0; m_phase = P_IDLE; m_lows = 0;
         return;
      end
      case (m_phase)
         P_IDLE: begin
            if (exc) take_exc();
            else if (start) begin m_phase = P_FETCH; m_lows = 0; end
         end
         P_FETCH: begin
            if (exc) begin
               take_exc();
               m_phase = P_IDLE;
            end else if (imem_ready) begin
               m_instr = imem_data; m_pc = m_pc + 32'd4; m_iv = 1'b1; m_phase = P_EXEC;
            end else begin
               m_lows++;
               if (m_lows > MAX_WAIT) begin
                  m_fe = 1'b1; m_epc = m_pc; m_pc = EXC_VECTOR; m_phase = P_IDLE;
               end
            end
         end
         default: begin
            if (exc) take_exc();
            else if (jr) m_pc = jr_addr;
            else if (jmp) m_pc = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
            else if (br_take) m_pc = m_pc + 32'(int'($signed(br_offset)) * 4);
            if (start) begin m_phase = P_FETCH; m_lows = 0; end
         end
      endcase
   endtask

   // One clock: advance the model, clock the DUT, compare every output.
   task automatic cyc();
      logic fetching;
      model_step();
      @(posedge clk);
      #1;
      fetching = (m_phase == P_FETCH);
      chk("pc", pc, m_pc);
      chk("epc", epc, m_epc);
      chk("instr", instr, m_instr);
      chk("instr_valid", 32'(instr_valid), 32'(m_iv));
      chk("fetch_err", 32'(fetch_err), 32'(m_fe));
      chk("imem_req", 32'(imem_req), 32'(fetching));
      chk("busy", 32'(busy), 32'(fetching));
      chk("imem_addr", imem_addr, fetching ? m_pc : 32'h0);
   endtask

   task automatic quiet();
      reset = 0; start = 0; imem_ready = 0; imem_data = 0; br_take = 0; br_offset = 0;
      jmp = 0; jr = 0; jr_addr = 0; exc = 0;
   endtask

   // From EXEC: jr to addr with start, then a ready fetch returning data.
   task automatic redirect_fetch(input logic [31:0] addr, input logic [31:0] data);
      quiet(); jr = 1; jr_addr = addr; start = 1; cyc();
      quiet(); imem_ready = 1; imem_data = data; cyc();
      quiet();
   endtask

   initial begin
      m_phase = P_IDLE; m_lows = 0; m_pc = 0; m_epc = 0; m_instr = 0; m_iv = 0; m_fe = 0;
      quiet();
      reset = 1;
      cyc(); cyc();
      chk("reset_pc", pc, 32'h0);
      chk("reset_req", 32'(imem_req), 32'h0);

      // First fetch from RESET_PC
      quiet(); start = 1; cyc();
      chk("fetch_addr", imem_addr, 32'h0);
      quiet(); imem_ready = 1; imem_data = 32'h2008_0005; cyc();
      chk("fetch_instr", instr, 32'h2008_0005);
      chk("fetch_pc", pc, 32'h4);
      chk("fetch_iv", 32'(instr_valid), 32'h1);
      quiet(); cyc();
      chk("iv_single_pulse", 32'(instr_valid), 32'h0);

      // Jump target keeps pc[31:28]
      redirect_fetch(32'hA000_0000, 32'h0800_0010);
      jmp = 1; cyc();
      chk("jmp_pc", pc, 32'hA000_0040);

      // Negative branch
      redirect_fetch(32'h0000_0004, 32'h1234_5678);
      br_take = 1; br_offset = 16'hFFFE; cyc();
      chk("br_neg_pc", pc, 32'h0);

      // PC+4 wrap
      redirect_fetch(32'hFFFF_FFFC, 32'h0000_0001);
      chk("wrap_pc", pc, 32'h0);

      // jr beats br_take
      quiet(); jr = 1; jr_addr = 32'h0000_1000; br_take = 1; br_offset = 16'h0005; cyc();
      chk("jr_over_br", pc, 32'h1000);

      // exc beats jr
      redirect_fetch(32'h0000_0020, 32'h0000_00AA);
      jr = 1; jr_addr = 32'h0000_1000; exc = 1; cyc();
      chk("exc_epc", epc, 32'h20);
      chk("exc_pc", pc, 32'h80);

      // Fetch timeout after MAX_WAIT+1 low-ready cycles
      quiet(); jr = 1; jr_addr = 32'h0000_0300; start = 1; cyc();
      quiet();
      for (int i = 0; i < MAX_WAIT; i++) cyc();
      chk("no_early_timeout", 32'(fetch_err), 32'h0);
      cyc();
      chk("timeout_err", 32'(fetch_err), 32'h1);
      chk("timeout_epc", epc, 32'h300);
      chk("timeout_pc", pc, 32'h80);
      chk("timeout_req", 32'(imem_req), 32'h0);
      cyc();
      chk("timeout_single_pulse", 32'(fetch_err), 32'h0);

      // exc with ready in FETCH discards data
      quiet(); start = 1; cyc();
      quiet(); exc = 1; imem_ready = 1; imem_data = 32'hDEAD_BEEF; cyc();
      chk("abort_instr", instr, 32'h0000_00AA);
      chk("abort_iv", 32'(instr_valid), 32'h0);
      chk("abort_pc", pc, 32'h80);

      // Reset wins over ready mid-fetch
      quiet(); start = 1; cyc();
      quiet(); reset = 1; imem_ready = 1; imem_data = 32'h5555_AAAA; cyc();
      chk("rst_pc", pc, RESET_PC);
      chk("rst_instr", instr, 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         reset      = ($urandom_range(0, 99) == 0);
         start      = ($urandom_range(0, 1) == 1);
         imem_ready = ($urandom_range(0, 9) < 6);
         imem_data  = $urandom;
         exc        = ($urandom_range(0, 15) == 0);
         jr         = ($urandom_range(0, 7) == 0);
         jr_addr    = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00};
         jmp        = ($urandom_range(0, 7) == 0);
         br_take    = ($urandom_range(0, 3) == 0);
         br_offset  = 16'($urandom);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the multicycle MIPS core. Owns the PC register, runs the instruction-fetch handshake with instruction memory, and applies control-flow redirects (branch, jump, jump-register, exception) in a fixed priority. The jump target is formed internally as {PC[31:28], instr[25:0], 2'b00}. The block sits between the control unit, which issues `start` and the redirect strobes, and the instruction memory port.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- EXC_VECTOR, 32'h0000_0080: PC loaded on exception or fetch timeout.
- MAX_WAIT, 15: last wait count tolerated before timeout. Range 1..255; 8-bit counter.

- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  control unit requests the next instruction fetch.
- imem_req  out  1  fetch request; high in every FETCH cycle.
- imem_addr  out  32  fetch address; equals `pc` while `imem_req` is high, 0 otherwise.
- imem_ready  in  1  memory returns data this cycle; `imem_data` is valid.
- imem_data  in  32  fetched instruction word.
- instr  out  32  registered, currently held instruction.
- instr_valid  out  1  one-cycle pulse when `instr` is newly loaded.
- busy  out  1  high when state is FETCH.
- br_take  in  1  take branch; offset is `br_offset`.
- br_offset  in  16  signed word offset.
- jmp  in  1  take jump using `instr[25:0]`.
- jr  in  1  jump to `jr_addr`.
- jr_addr  in  32  register jump target.
- exc  in  1  exception request.
- pc  out  32  current PC.
- epc  out  32  saved exception PC.
- fetch_err  out  1  one-cycle pulse on fetch timeout.

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE:
  - `start` goes to FETCH and clears the wait counter.
  - `br_take`, `jmp` and `jr` are ignored.
- FETCH:
  - On `imem_ready`:
    - `instr <= imem_data`
    - `pc <= pc + 4`
    - `instr_valid` pulses
    - go to EXEC
  - On `!imem_ready` with counter < MAX_WAIT: increment the counter.
  - On `!imem_ready` with counter == MAX_WAIT (timeout):
    - `fetch_err` pulses
    - `epc <= pc`
    - `pc <= EXC_VECTOR`
    - go to IDLE
  - `start` and the branch/jump strobes are ignored.
- EXEC. `pc` already holds PC+4. Redirect priority, highest first; only the highest asserted redirect is applied:
  - `exc`: `epc <= pc - 4`, `pc <= EXC_VECTOR`.
  - `jr`: `pc <= jr_addr`.
  - `jmp`: `pc <= {pc[31:28], instr[25:0], 2'b00}`.
  - `br_take`: `pc <= pc + (sign_extend(br_offset) << 2)`.
- EXEC transitions:
  - `start` goes to FETCH. If a redirect is applied in the same cycle, the fetch uses the redirected PC.
  - With no `start`, the block stays in EXEC.
- `exc` in FETCH aborts the fetch: same update as `exc` in EXEC, then go to IDLE. `imem_ready` arriving in that same cycle is discarded and `instr` is unchanged.
- `exc` in IDLE: same PC/EPC update as in EXEC; the block stays in IDLE.
- Arithmetic is 32-bit modulo. PC+4 at 32'hFFFF_FFFC wraps to 0, and branch targets wrap the same way.
- `jr_addr` is loaded unaligned as-is; no alignment check.

## Timing
- Reset values:
  - `pc` = RESET_PC
  - `epc`, `instr` = 0
  - `instr_valid`, `fetch_err`, `imem_req`, `busy` = 0
  - state = IDLE, wait counter = 0
- Reset asserted mid-fetch wins over `imem_ready`. `imem_req` is low in the cycle after reset is sampled.
- `imem_req`, `imem_addr` and `busy` decode from registered state only. There is no combinational path from any input to these outputs.
- Fetch latency:
  - `start` sampled at edge t gives `imem_req` = 1 during cycle t+1.
  - If `imem_ready` is high in that cycle, `instr_valid` = 1 and the new `pc` are seen in cycle t+2.
  - Minimum latency is 2 cycles; each low-ready cycle adds 1.
- Timeout: `fetch_err` is high in the cycle after the (MAX_WAIT+1)-th consecutive low-ready FETCH cycle.
- Redirects take effect on `pc` one cycle after they are sampled.
- `instr_valid` and `fetch_err` are never high for two consecutive cycles.

## Test plan
- Reset, `start`, `imem_ready` high in the first FETCH cycle, `imem_data` = 32'h2008_0005 -> `imem_addr` = 0; next cycle `instr` = 32'h2008_0005, `pc` = 4, `instr_valid` pulses once.
- `pc` = 32'hA000_0004 in EXEC, `instr` = 32'h0800_0010, `jmp` -> `pc` = 32'hA000_0040.
- `pc` = 8 in EXEC, `br_take` with `br_offset` = 16'hFFFE -> `pc` = 0.
- `pc` = 32'hFFFF_FFFC in FETCH with ready -> `pc` = 0.
- `jr` (`jr_addr` = 32'h0000_1000) with `br_take` -> `pc` = 32'h1000.
- `jr` with `exc` in the same cycle, `pc` = 32'h0000_0024 -> `epc` = 32'h20, `pc` = 32'h80.
- MAX_WAIT = 3, `imem_ready` held low in FETCH -> `fetch_err` pulses after 4 wait cycles, `epc` = old `pc`, `pc` = 32'h80, `imem_req` low, state IDLE.
- `exc` with `imem_ready` in the same FETCH cycle -> `instr` unchanged, `instr_valid` stays 0, `pc` = 32'h80.
- Reset asserted during FETCH with ready -> `pc` = RESET_PC, `instr` = 0, `imem_req` = 0 next cycle.
